// File: rtl/line_buf_unit.sv
// Round-robin line buffer between the pixel stream and cntl_unit: rows are written into NM
// buffers, per-buffer reads have one-cycle latency, and mem_used releases buffers. Optional: LBUF_ERR_CHK_EN.
module line_buf_unit #(
  parameter int XB = 10,
  parameter int YB = 10,
  parameter int PB = 8,
  parameter int NM = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XB-1:0]          cfg_width,
  input  logic [YB-1:0]          cfg_height,
  input  logic [PB-1:0]          pix_in,
  input  logic                   pix_in_vld,
  output logic                   pix_in_rdy,
  input  logic [NM-1:0]          mem_used,
  input  logic [NM-1:0][XB-1:0]  mb_rd_addr,
  output logic [NM-1:0][PB-1:0]  pu_data,
  output logic [NM-1:0]          mb_full,
  output logic [NM-1:0]          mb_minfill,
  output logic                   wr_frame_done,
  output logic [1:0]             lb_err
);

  localparam int SB = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = $clog2(NM + 1);

  logic [XB-1:0] wr_col;
  logic [YB-1:0] wr_row;
  logic [SB-1:0] wr_sel;
  logic          acc;
  logic          row_end;
  logic          frame_end;
  logic [NM-1:0] set_vec;
  logic [CW-1:0] full_cnt;

  // Handshake: a pixel transfers on a rising edge where pix_in_vld && pix_in_rdy;
  // pix_in_rdy depends only on registered state, never on pix_in_vld.
  assign pix_in_rdy = !mb_full[wr_sel];
  assign acc        = pix_in_vld && pix_in_rdy;
  // A zero config wraps to the all-ones last index, giving 2^XB columns / 2^YB rows.
  assign row_end    = (wr_col == cfg_width - 1'b1);
  assign frame_end  = (wr_row == cfg_height - 1'b1);

  always_comb begin
    set_vec = '0;
    for (int i = 0; i < NM; i++) begin
      set_vec[i] = acc && row_end && (wr_sel == SB'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_col        <= '0;
      wr_row        <= '0;
      wr_sel        <= '0;
      mb_full       <= '0;
      wr_frame_done <= 1'b0;
    end else begin
      // A release colliding with the row-completing write loses: the buffer ends up full.
      mb_full       <= (mb_full & ~mem_used) | set_vec;
      wr_frame_done <= acc && row_end && frame_end;
      if (acc) begin
        if (row_end) begin
          wr_col <= '0;
          if (frame_end) begin
            wr_row <= '0;
            wr_sel <= '0;
          end else begin
            wr_row <= wr_row + 1'b1;
            wr_sel <= (wr_sel == SB'(NM - 1)) ? '0 : wr_sel + 1'b1;
          end
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
    end
  end

  always_comb begin
    full_cnt = '0;
    for (int i = 0; i < NM; i++) begin
      full_cnt = full_cnt + CW'(mb_full[i]);
    end
  end

  always_comb begin
    mb_minfill = '0;
    for (int k = 0; k < NM; k++) begin
      mb_minfill[k] = (full_cnt >= CW'(k + 1));
    end
  end

  for (genvar g = 0; g < NM; g++) begin : g_buf
    logic [PB-1:0] mem [0:(1<<XB)-1];
    logic [PB-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (acc && (wr_sel == SB'(g))) begin
        mem[wr_col] <= pix_in;
      end
    end

    // Read-first: a same-cycle write to the read address returns the old word.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
      end else begin
        rd_q <= mem[mb_rd_addr[g]];
      end
    end

    assign pu_data[g] = rd_q;
  end

`ifdef LBUF_ERR_CHK_EN
  logic [1:0] err_q;
  logic       rd_oob;

  always_comb begin
    rd_oob = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (mb_full[i] && (cfg_width != '0) && (mb_rd_addr[i] >= cfg_width)) begin
        rd_oob = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      if (|(mem_used & ~mb_full & ~set_vec)) err_q[0] <= 1'b1;
      if (rd_oob)                            err_q[1] <= 1'b1;
    end
  end

  assign lb_err = err_q;
`else
  assign lb_err = 2'b00;
`endif

endmodule

// File: tb/tb_line_buf_unit.sv
// Directed bench for line_buf_unit: read data is checked by a monitor against an expected queue;
// status outputs are checked directly after each step.
module tb_line_buf_unit;

  localparam int XB = 10;
  localparam int YB = 10;
  localparam int PB = 8;
  localparam int NM = 4;

`ifdef LBUF_ERR_CHK_EN
  localparam logic [1:0] E_USED = 2'b01;
  localparam logic [1:0] E_BOTH = 2'b11;
`else
  localparam logic [1:0] E_USED = 2'b00;
  localparam logic [1:0] E_BOTH = 2'b00;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [XB-1:0]         cfg_width;
  logic [YB-1:0]         cfg_height;
  logic [PB-1:0]         pix_in;
  logic                  pix_in_vld;
  logic                  pix_in_rdy;
  logic [NM-1:0]         mem_used;
  logic [NM-1:0][XB-1:0] mb_rd_addr;
  logic [NM-1:0][PB-1:0] pu_data;
  logic [NM-1:0]         mb_full;
  logic [NM-1:0]         mb_minfill;
  logic                  wr_frame_done;
  logic [1:0]            lb_err;

  int checks = 0;
  int errors = 0;
  logic [PB-1:0] exp_q[$];
  logic          rd_req = 1'b0;
  int            rd_buf = 0;

  line_buf_unit #(.XB(XB), .YB(YB), .PB(PB), .NM(NM)) dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .pix_in(pix_in), .pix_in_vld(pix_in_vld), .pix_in_rdy(pix_in_rdy),
    .mem_used(mem_used), .mb_rd_addr(mb_rd_addr), .pu_data(pu_data),
    .mb_full(mb_full), .mb_minfill(mb_minfill), .wr_frame_done(wr_frame_done),
    .lb_err(lb_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // driver tasks (entered and left on a negedge)
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [PB-1:0] v);
    chk("rdy_before_push", {31'b0, pix_in_rdy}, 32'd1);
    pix_in = v;
    pix_in_vld = 1'b1;
    @(negedge clk);
    pix_in_vld = 1'b0;
  endtask

  task automatic rel(input logic [NM-1:0] m);
    mem_used = m;
    @(negedge clk);
    mem_used = '0;
  endtask

  task automatic do_read(input int b, input logic [XB-1:0] a, input logic [PB-1:0] e);
    mb_rd_addr[b] = a;
    rd_buf = b;
    exp_q.push_back(e);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    mb_rd_addr[b] = '0;
  endtask

  // scoreboard monitor: compares pu_data one cycle after each read request
  initial begin
    int b;
    logic [PB-1:0] e;
    forever begin
      @(posedge clk);
      if (rd_req) begin
        b = rd_buf;
        @(negedge clk);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got data %0h with empty queue, required queued entry", pu_data[b]);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (pu_data[b] !== e) begin
            errors++;
            $display("FAIL rd_data buf%0d: got %0h, required %0h", b, pu_data[b], e);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_width = 10'd8; cfg_height = 10'd4;
    pix_in = '0; pix_in_vld = 1'b0; mem_used = '0; mb_rd_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_full",    32'(mb_full), 0);
    chk("rst_minfill", 32'(mb_minfill), 0);
    chk("rst_rdy",     32'(pix_in_rdy), 1);
    chk("rst_fdone",   32'(wr_frame_done), 0);
    chk("rst_err",     32'(lb_err), 0);
    chk("rst_pu",      32'(pu_data), 0);

    // fill and read
    for (int p = 0; p < 8; p++) begin
      push(PB'(p));
      if (p == 6) chk("fill_partial", 32'(mb_full), 32'b0000);
    end
    chk("fill_row0", 32'(mb_full), 32'b0001);
    for (int p = 8; p < 16; p++) push(PB'(p));
    chk("fill_row1",    32'(mb_full), 32'b0011);
    chk("fill_minfill", 32'(mb_minfill), 32'b0011);
    do_read(1, 10'd3, 8'd11);
    do_read(0, 10'd7, 8'd7);

    // backpressure and frame end at 4 rows
    for (int p = 16; p < 32; p++) push(PB'(p));
    chk("bp_fdone",   32'(wr_frame_done), 1);
    chk("bp_full",    32'(mb_full), 32'b1111);
    chk("bp_minfill", 32'(mb_minfill), 32'b1111);
    chk("bp_rdy",     32'(pix_in_rdy), 0);
    pix_in = 8'd32;
    pix_in_vld = 1'b1;
    @(negedge clk);
    chk("bp_fdone_low", 32'(wr_frame_done), 0);
    chk("bp_stall_full", 32'(mb_full), 32'b1111);
    rel(4'b0001);
    chk("bp_rel_full", 32'(mb_full), 32'b1110);
    chk("bp_rel_rdy",  32'(pix_in_rdy), 1);
    @(negedge clk);
    pix_in_vld = 1'b0;
    chk("bp_after_full", 32'(mb_full), 32'b1110);
    do_read(0, 10'd0, 8'd32);
    do_read(1, 10'd0, 8'd8);

    // frame wrap at height 3, width 4
    do_reset();
    cfg_width = 10'd4; cfg_height = 10'd3;
    for (int p = 0; p < 12; p++) begin
      push(PB'(100 + p));
      if (p % 4 == 3) begin
        chk("wrap_fdone", 32'(wr_frame_done), (p == 11) ? 32'd1 : 32'd0);
        rel(NM'(1 << (p / 4)));
        if (p == 11) chk("wrap_fdone_low", 32'(wr_frame_done), 0);
      end
    end
    chk("wrap_full", 32'(mb_full), 0);
    push(8'd112);
    do_read(0, 10'd0, 8'd112);
    do_read(1, 10'd0, 8'd104);

    // set-wins coincidence on buffer 2
    do_reset();
    cfg_width = 10'd4; cfg_height = 10'd4;
    for (int p = 0; p < 8; p++) begin
      push(PB'(p));
      if (p % 4 == 3) rel(NM'(1 << (p / 4)));
    end
    for (int p = 8; p < 11; p++) push(PB'(p));
    pix_in = 8'd11; pix_in_vld = 1'b1; mem_used = 4'b0100;
    @(negedge clk);
    pix_in_vld = 1'b0; mem_used = '0;
    chk("setwin_full",    32'(mb_full), 32'b0100);
    chk("setwin_minfill", 32'(mb_minfill), 32'b0001);
    chk("setwin_err",     32'(lb_err), 0);
    do_read(2, 10'd3, 8'd11);

    // reset mid-row
    do_reset();
    cfg_width = 10'd8; cfg_height = 10'd4;
    for (int p = 0; p < 5; p++) push(PB'(200 + p));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_full",    32'(mb_full), 0);
    chk("midrst_minfill", 32'(mb_minfill), 0);
    chk("midrst_fdone",   32'(wr_frame_done), 0);
    chk("midrst_err",     32'(lb_err), 0);
    chk("midrst_pu",      32'(pu_data), 0);
    chk("midrst_rdy",     32'(pix_in_rdy), 1);
    rst = 1'b0;
    push(8'hAA);
    do_read(0, 10'd0, 8'hAA);

    // error flags
    for (int p = 1; p < 8; p++) push(PB'(p));
    chk("err_full", 32'(mb_full), 32'b0001);
    chk("err_none", 32'(lb_err), 0);
    rel(4'b0100);
    chk("err_used", 32'(lb_err), 32'(E_USED));
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(lb_err), 32'(E_USED));
    mb_rd_addr[0] = 10'd9;
    @(negedge clk);
    mb_rd_addr[0] = '0;
    chk("err_oob", 32'(lb_err), 32'(E_BOTH));
    do_reset();
    chk("err_cleared", 32'(lb_err), 0);

    // final report
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_queue_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buf_unit.md
# line_buf_unit

- Memory unit sitting between the incoming pixel stream and `cntl_unit`.
- Accepts raster pixels over a valid/ready handshake and writes them row by row into `NM` line buffers, filled round-robin.
- Reports per-buffer full status and fill level to the control unit, serves its per-buffer reads with one-cycle latency, and frees buffers when the control unit releases them via `mem_used`.

## Interface
- `XB`, 10, column address width; each buffer holds 2^XB pixels
- `YB`, 10, row counter width
- `PB`, 8, pixel width
- `NM`, 4, number of line buffers
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `cfg_width` in XB: pixels per row
- `cfg_height` in YB: rows per frame
- `pix_in` in PB: input pixel
- `pix_in_vld` in 1: input pixel valid
- `pix_in_rdy` out 1: block can accept `pix_in`
- `mem_used` in NM: one-cycle release pulse per buffer
- `mb_rd_addr` in XB×[NM]: read address per buffer
- `pu_data` out PB×[NM]: read data per buffer
- `mb_full` out NM: buffer holds a complete row
- `mb_minfill` out NM: fill-level flags
- `wr_frame_done` out 1: one-cycle pulse at end of frame
- `lb_err` out 2: sticky error flags (see Configuration)

## Operation
- **Counters:**
  - `wr_col` (XB bits) counts accepted pixels in the current row.
  - `wr_row` (YB bits) counts completed rows.
  - `wr_sel` (log2 NM bits) selects the target buffer.
- **Accept:** a pixel is accepted on a rising edge with `pix_in_vld && pix_in_rdy`.
  - `pix_in_rdy = !mb_full[wr_sel]`, combinational from registers.
- **Write:** on accept, `mem[wr_sel][wr_col] <= pix_in` and `wr_col` increments.
- **End of row:** when `wr_col == cfg_width-1` (XB-bit arithmetic) on accept:
  - `wr_col` goes to 0.
  - `mb_full[wr_sel]` is set.
  - `wr_sel` goes to (`wr_sel`+1) mod NM.
  - `wr_row` increments.
- **End of frame:** if the end-of-row accept also has `wr_row == cfg_height-1`:
  - `wr_row` goes to 0.
  - `wr_sel` goes to 0.
  - `wr_frame_done` pulses high the next cycle.
- **Release:** `mem_used[i]` clears `mb_full[i]` on the next edge. Multiple bits may pulse in the same cycle.
- **Fill level:** `mb_minfill[k] = (popcount(mb_full) >= k+1)`, combinational from `mb_full`. `mb_minfill[1]` means at least two complete rows are available.
- **Read:** `pu_data[i] <= mem[i][mb_rd_addr[i]]` every cycle, unconditionally.
- **Boundary cases:**
  - `cfg_width == 0` gives 2^XB pixels per row; `cfg_height == 0` gives 2^YB rows.
  - `cfg_width` and `cfg_height` are stable while a frame is in progress. Changes take effect only after `wr_frame_done` or reset.
  - A `mem_used[i]` pulse on a non-full buffer is ignored. If it coincides with the last write of buffer `i`'s row, the set wins and the buffer becomes full.
  - If all NM buffers are full, `pix_in_rdy` is 0 and the stream stalls. No pixel is dropped or overwritten.
- **Reset:**
  - All counters, `mb_full`, `pu_data`, `wr_frame_done` and `lb_err` go to 0.
  - `pix_in_rdy` is 1 after reset.
  - Memory contents are not cleared.
  - Reset mid-row discards the partial row; the next accepted pixel goes to buffer 0, column 0.

## Timing
- **Write-to-full:** `mb_full[i]` and `mb_minfill` rise in the cycle after the last pixel of the row is accepted.
- **Release-to-ready:** `mb_full[i]` falls the cycle after `mem_used[i]`. `pix_in_rdy` can rise in that same cycle.
- **Read latency:** 1 cycle from `mb_rd_addr[i]` to `pu_data[i]`.
- **Read/write collision:** reading the address being written in the same cycle returns the old contents (read-first).
- **Throughput:** one pixel per cycle when not stalled.
- **Frame-done timing:** `wr_frame_done` is high for exactly one cycle, the cycle after the final accept of the frame.

## Configuration
- **`LBUF_ERR_CHK_EN` defined:** `lb_err` is sticky until reset.
  - `lb_err[0]` sets on `mem_used[i]` for a buffer with `mb_full[i] == 0`, unless the set-wins coincidence above applies.
  - `lb_err[1]` sets when `mb_rd_addr[i] >= cfg_width` for any `i` with `mb_full[i] == 1`, checked only when `cfg_width != 0`.
- **Not defined:** `lb_err` is tied to 2'b00, the checking logic is absent, and all other behaviour is identical.

## Test plan
All scenarios use NM=4, XB=10, PB=8.
- **Fill and read:** `cfg_width=8`, `cfg_height=4`, stream pixels 0..15 without releases.
  - `mb_full` goes 0001 then 0011; `mb_minfill` becomes 0011.
  - `mb_rd_addr[1]=3` returns 11 one cycle later.
- **Backpressure:** stream 32 pixels at width 8 with no `mem_used`.
  - After 32 accepts, `mb_full`=1111 and `pix_in_rdy`=0.
  - Pulse `mem_used`=0001; the next cycle `pix_in_rdy`=1 and pixel 32 lands in buffer 0, column 0.
- **Frame wrap:** `cfg_height=3`, width 4, releasing each buffer as it fills.
  - `wr_frame_done` pulses once, the cycle after pixel 11 is accepted.
  - Pixel 12 writes buffer 0.
- **Set-wins coincidence:** `mem_used[2]` in the same cycle as the last pixel of buffer 2's row.
  - `mb_full[2]`=1 afterwards.
  - With `LBUF_ERR_CHK_EN`, `lb_err`=00.
- **Reset mid-row:** assert `rst` after 5 pixels at width 8.
  - All outputs are 0 except `pix_in_rdy`=1.
  - The next pixel, value 0xAA, reads back at buffer 0, address 0.
- **Error checks (`LBUF_ERR_CHK_EN`):**
  - `mem_used`=0100 while `mb_full`=0001 sets `lb_err[0]`, which stays set until `rst`.
  - `mb_rd_addr[0]=9` with `cfg_width=8` and `mb_full[0]`=1 sets `lb_err[1]`.
